// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA frame-buffer read path: FSM encoding,
// frame-buffer bank bases and the active-video geometry that sizes a frame.
package vga_fb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CHECK,
        S_REQ,
        S_WAIT
    } fb_state_e;

    localparam int H_ACTIVE        = 1024;
    localparam int V_ACTIVE        = 768;
    localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE;

    localparam logic [23:0] BANK0_BASE_DEF = 24'h000000;
    localparam logic [23:0] BANK1_BASE_DEF = 24'h100000;

endpackage

// File: rtl/vga_fb_bank_ctrl.sv
// Ping-pong bank ownership: a finished camera frame is parked until the reader
// restarts a frame, at which point the two banks trade roles.
module vga_fb_bank_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_frame_done_i,
    input  logic swap_i,
    output logic wr_bank_o,
    output logic rd_bank_o,
    output logic wr_allow_o
);

    logic swap_pend_q, swap_pend_d;
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;

    always_comb begin
        swap_pend_d = swap_pend_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        // A second frame-done while one is already parked is dropped.
        if (swap_pend_q) begin
            if (swap_i) begin
                rd_bank_d   = wr_bank_q;
                wr_bank_d   = ~wr_bank_q;
                swap_pend_d = 1'b0;
            end
        end else if (wr_frame_done_i) begin
            swap_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            swap_pend_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
        end else begin
            swap_pend_q <= swap_pend_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    assign wr_bank_o  = wr_bank_q;
    assign rd_bank_o  = rd_bank_q;
    assign wr_allow_o = ~swap_pend_q;

endmodule

// File: rtl/vga_fb_rd_scheduler.sv
// Issues SDRAM burst reads that keep the VGA line FIFO topped up, restarting
// the read of the current bank at every frame start.
module vga_fb_rd_scheduler
    import vga_fb_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter int                FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int                BURST_LEN   = 256,
    parameter int                LEN_W       = 9,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                CNT_W       = 11,
    parameter logic [ADDR_W-1:0] BANK0_BASE  = BANK0_BASE_DEF,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = BANK1_BASE_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              v_sync,
    input  logic [CNT_W-1:0]  fifo_rd_cnt,
    output logic              fifo_clr,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              rd_done,
    input  logic              wr_frame_done,
    output logic              wr_bank,
    output logic              wr_allow,
    output logic              rd_bank,
    output logic              rd_underrun
);

    localparam int               WL_W        = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] FILL_THRESH = CNT_W'(FIFO_DEPTH - BURST_LEN);

    fb_state_e         state_q, state_d;
    logic              v_sync_q;
    logic              fs_pend_q, fs_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic              underrun_q, underrun_d;

    logic              fs, fs_any, enter_clr;
    logic [LEN_W-1:0]  burst_len;
    logic [WL_W-1:0]   len_wl;

    assign fs        = v_sync_q & ~v_sync;
    assign fs_any    = fs | fs_pend_q;
    assign burst_len = (32'(words_left_q) >= BURST_LEN) ? LEN_W'(BURST_LEN)
                                                        : LEN_W'(words_left_q);
    assign len_wl    = WL_W'(rd_len_q);

    always_comb begin
        state_d      = state_q;
        fs_pend_d    = fs_pend_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        rd_addr_d    = rd_addr_q;
        rd_len_d     = rd_len_q;
        underrun_d   = underrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (fs_any) state_d = S_CLR;
            end
            S_CLR: begin
                // rd_bank already reflects any swap taken on entry to this state.
                addr_d       = rd_bank ? BANK1_BASE : BANK0_BASE;
                words_left_d = WL_W'(FRAME_WORDS);
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                if (fs_any) begin
                    if (words_left_q != '0) underrun_d = 1'b1;
                    state_d = S_CLR;
                end else if (words_left_q == '0) begin
                    state_d = S_IDLE;
                end else if (fifo_rd_cnt <= FILL_THRESH) begin
                    rd_addr_d = addr_q;
                    rd_len_d  = burst_len;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_done) begin
                    addr_d       = addr_q + ADDR_W'(rd_len_q);
                    words_left_d = (len_wl >= words_left_q) ? '0 : words_left_q - len_wl;
                    state_d      = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A frame start seen mid-burst is remembered until the reader restarts.
        enter_clr = (state_d == S_CLR) && (state_q != S_CLR);
        if (enter_clr)
            fs_pend_d = 1'b0;
        else if (fs && (state_q != S_IDLE) && (state_q != S_CHECK))
            fs_pend_d = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            v_sync_q     <= 1'b0;
            fs_pend_q    <= 1'b0;
            addr_q       <= '0;
            words_left_q <= '0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_sync_q     <= v_sync;
            fs_pend_q    <= fs_pend_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            underrun_q   <= underrun_d;
        end
    end

    vga_fb_bank_ctrl u_bank_ctrl (
        .clk_i           (sys_clk),
        .rst_i           (rst),
        .wr_frame_done_i (wr_frame_done),
        .swap_i          (enter_clr),
        .wr_bank_o       (wr_bank),
        .rd_bank_o       (rd_bank),
        .wr_allow_o      (wr_allow)
    );

    assign fifo_clr    = (state_q == S_CLR);
    assign rd_req      = (state_q == S_REQ);
    assign rd_addr     = rd_addr_q;
    assign rd_len      = rd_len_q;
    assign rd_underrun = underrun_q;

endmodule

// File: tb/tb_vga_fb_rd_scheduler.sv
// Directed bench for vga_fb_rd_scheduler with a transaction-level frame/burst
// model checked every cycle, run with a short 600-word frame.
module tb_vga_fb_rd_scheduler;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 9;
    localparam int CNT_W  = 11;
    localparam int FW     = 600;
    localparam int BL     = 256;
    localparam int THR    = 1024 - 256;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              v_sync = 1'b1;
    logic [CNT_W-1:0]  fifo_rd_cnt = '0;
    logic              rd_ack = 1'b0;
    logic              rd_done = 1'b0;
    logic              wr_frame_done = 1'b0;
    logic              fifo_clr, rd_req, wr_bank, wr_allow, rd_bank, rd_underrun;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    vga_fb_rd_scheduler #(
        .FRAME_WORDS (FW)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .v_sync        (v_sync),
        .fifo_rd_cnt   (fifo_rd_cnt),
        .fifo_clr      (fifo_clr),
        .rd_req        (rd_req),
        .rd_ack        (rd_ack),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_done       (rd_done),
        .wr_frame_done (wr_frame_done),
        .wr_bank       (wr_bank),
        .wr_allow      (wr_allow),
        .rd_bank       (rd_bank),
        .rd_underrun   (rd_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [23:0] a;
        int          l;
    } burst_t;

    burst_t      mq[$];
    int          m_e = 0;
    int          m_chk_from = 0;
    int          m_cur_l = 0;
    logic [23:0] m_cur_a = '0;
    bit m_prev_vs, m_wr, m_rd, m_swap, m_under, m_posted, m_flight, m_chk, m_fsw, m_clr;

    task automatic m_reset();
        m_prev_vs = 0; m_wr = 0; m_rd = 1; m_swap = 0; m_under = 0;
        m_posted = 0; m_flight = 0; m_chk = 0; m_fsw = 0; m_clr = 0;
        mq.delete();
    endtask

    // New frame: optional bank swap, then the whole frame split into bursts.
    task automatic m_restart();
        logic [23:0] base;
        if (m_swap) begin
            m_rd   = m_wr;
            m_wr   = ~m_wr;
            m_swap = 0;
        end
        base = m_rd ? 24'h100000 : 24'h000000;
        mq.delete();
        for (int off = 0; off < FW; off += BL)
            mq.push_back('{a: base + 24'(off), l: ((FW - off) < BL) ? (FW - off) : BL});
        m_fsw      = 0;
        m_clr      = 1;
        m_chk      = 1;
        m_chk_from = m_e + 2;
    endtask

    initial begin : model_and_compare
        bit fs, was_swap;
        m_reset();
        forever begin
            @(posedge sys_clk);
            m_e++;
            if (rst) begin
                m_reset();
            end else begin
                fs        = m_prev_vs && !v_sync;
                m_prev_vs = v_sync;
                was_swap  = m_swap;
                m_clr     = 0;
                if (m_posted) begin
                    if (rd_ack) begin m_posted = 0; m_flight = 1; end
                    if (fs) m_fsw = 1;
                end else if (m_flight) begin
                    if (rd_done) begin m_flight = 0; m_chk = 1; m_chk_from = m_e + 1; end
                    if (fs) m_fsw = 1;
                end else if (m_chk && m_e < m_chk_from) begin
                    if (fs) m_fsw = 1;
                end else if (m_chk) begin
                    if (fs || m_fsw) begin
                        if (mq.size() != 0) m_under = 1;
                        m_restart();
                    end else if (mq.size() == 0) begin
                        m_chk = 0;
                    end else if (int'(fifo_rd_cnt) <= THR) begin
                        m_cur_a = mq[0].a;
                        m_cur_l = mq[0].l;
                        void'(mq.pop_front());
                        m_posted = 1;
                        m_chk    = 0;
                    end
                end else if (fs || m_fsw) begin
                    m_restart();
                end
                if (wr_frame_done && !was_swap) m_swap = 1;
            end

            @(negedge sys_clk);
            if (rst) begin
                check("m_rst_req", rd_req, 0);
                check("m_rst_clr", fifo_clr, 0);
                check("m_rst_addr", rd_addr, 0);
                check("m_rst_len", rd_len, 0);
                check("m_rst_wrbank", wr_bank, 0);
                check("m_rst_rdbank", rd_bank, 1);
                check("m_rst_allow", wr_allow, 1);
                check("m_rst_under", rd_underrun, 0);
            end else begin
                check("m_req", rd_req, m_posted);
                if (m_posted) begin
                    check("m_addr", rd_addr, m_cur_a);
                    check("m_len", rd_len, m_cur_l);
                end
                check("m_clr", fifo_clr, m_clr);
                check("m_wrbank", wr_bank, m_wr);
                check("m_rdbank", rd_bank, m_rd);
                check("m_allow", wr_allow, !m_swap);
                check("m_under", rd_underrun, m_under);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_req(input logic [23:0] ea, input int el, input string nm);
        int k = 0;
        while (rd_req !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check({nm, "_req"}, rd_req, 1);
        check({nm, "_addr"}, rd_addr, ea);
        check({nm, "_len"}, rd_len, el);
        $display("[TB] burst %s addr=%06h len=%0d", nm, rd_addr, rd_len);
    endtask

    task automatic do_ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic do_done();
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin : stimulus
        repeat (3) tick();
        check("rst_req", rd_req, 0);
        check("rst_clr", fifo_clr, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_len", rd_len, 0);
        check("rst_wrbank", wr_bank, 0);
        check("rst_rdbank", rd_bank, 1);
        check("rst_allow", wr_allow, 1);
        check("rst_under", rd_underrun, 0);
        rst = 1'b0;
        repeat (2) tick();

        // First frame start: clear one cycle later, request two cycles after that.
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        check("t1_clr", fifo_clr, 1);
        tick();
        check("t1_clr_once", fifo_clr, 0);
        check("t1_noreq_yet", rd_req, 0);
        tick();
        check("t1_req", rd_req, 1);
        check("t1_addr", rd_addr, 24'h100000);
        check("t1_len", rd_len, 256);
        check("t1_rdbank", rd_bank, 1);
        $display("[TB] burst t1_b1 addr=%06h len=%0d", rd_addr, rd_len);
        tick();
        check("t1_hold_req", rd_req, 1);
        check("t1_hold_addr", rd_addr, 24'h100000);
        do_ack();
        check("t1_req_drop", rd_req, 0);

        // FIFO too full: no request until the count drops to the threshold.
        fifo_rd_cnt = 11'd800;
        do_done();
        repeat (3) begin
            tick();
            check("t2_full_noreq", rd_req, 0);
        end
        fifo_rd_cnt = 11'd768;
        tick();
        check("t2_req_768", rd_req, 1);
        check("t2_addr", rd_addr, 24'h100100);
        check("t2_len", rd_len, 256);
        $display("[TB] burst t2_b2 addr=%06h len=%0d", rd_addr, rd_len);
        fifo_rd_cnt = '0;
        do_ack();
        do_done();

        // Frame tail: short last burst, then silence.
        wait_req(24'h100200, 88, "t3_b3");
        do_ack();
        do_done();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_idle_noreq", rd_req, 0);
        end

        // Bank swap on the next frame start; repeated frame-done is ignored.
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        check("t4_allow_low", wr_allow, 0);
        tick();
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        check("t4_dup_allow", wr_allow, 0);
        check("t4_dup_wrbank", wr_bank, 0);
        check("t4_dup_rdbank", rd_bank, 1);
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        check("t4_clr", fifo_clr, 1);
        check("t4_rdbank", rd_bank, 0);
        check("t4_wrbank", wr_bank, 1);
        check("t4_allow", wr_allow, 1);
        wait_req(24'h000000, 256, "t4_b1");
        do_ack();

        // Frame start during a burst: burst completes, underrun, restart on new bank.
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        check("t5_no_abort", fifo_clr, 0);
        do_done();
        check("t5_under_pre", rd_underrun, 0);
        tick();
        check("t5_under", rd_underrun, 1);
        check("t5_clr", fifo_clr, 1);
        check("t5_rdbank", rd_bank, 1);
        check("t5_wrbank", wr_bank, 0);
        wait_req(24'h100000, 256, "t5_restart");

        // Asynchronous reset while a request is posted.
        rst = 1'b1;
        #1;
        check("t6_async_req", rd_req, 0);
        check("t6_addr", rd_addr, 0);
        check("t6_len", rd_len, 0);
        check("t6_under", rd_underrun, 0);
        check("t6_rdbank", rd_bank, 1);
        check("t6_wrbank", wr_bank, 0);
        check("t6_allow", wr_allow, 1);
        tick();
        rst = 1'b0;
        tick();
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        check("t6_clr_after", fifo_clr, 1);
        wait_req(24'h100000, 256, "t6_b1");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
